// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the two-master BRAM port arbiter.
package bram_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t own_state(input logic id);
    return id ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Memory request/response bundle; lock is only meaningful on the master side of the arbiter.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_lock;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_lock,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_lock,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/bram_port_arbiter_rr2_pick.sv
// Two-way round-robin pick: on a tie the master that did not win last time goes next.
module bram_port_arbiter_rr2_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_id
);
  assign o_valid = i_req0 | i_req1;
  assign o_id    = (i_req0 & i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two masters; grant is registered and parks on the last owner.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = XLEN,
  parameter int DATA_W   = XLEN,
  parameter int LOCK_MAX = 8
) (
  input logic                clk,
  input logic                rst,
  bram_port_arbiter_if.slave  m0,
  bram_port_arbiter_if.slave  m1,
  bram_port_arbiter_if.master s
);
  localparam int HC_W = $clog2(LOCK_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(LOCK_MAX - 1);

  arb_state_t      r_state;
  arb_state_t      w_state_next;
  logic            r_last;
  logic            w_last_next;
  logic [HC_W-1:0] r_hold_cnt;
  logic [HC_W-1:0] w_hold_next;

  logic w_pick_valid;
  logic w_pick_id;
  logic w_owner_id;
  logic w_own_req;
  logic w_own_lock;
  logic w_oth_req;
  logic w_busy;

  logic              w_fwd_req;
  logic              w_fwd_we;
  logic [ADDR_W-1:0] w_fwd_addr;
  logic [DATA_W-1:0] w_fwd_wdata;

  bram_port_arbiter_rr2_pick u_pick (
    .i_req0  (m0.mem_req),
    .i_req1  (m1.mem_req),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_id    (w_pick_id)
  );

  assign w_owner_id = (r_state == ARB_OWN1);
  assign w_own_req  = w_owner_id ? m1.mem_req  : m0.mem_req;
  assign w_own_lock = w_owner_id ? m1.mem_lock : m0.mem_lock;
  assign w_oth_req  = w_owner_id ? m0.mem_req  : m1.mem_req;
  assign w_busy     = w_own_req & ~s.mem_ready;

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_hold_next  = r_hold_cnt;
    case (r_state)
      ARB_IDLE: begin
        w_hold_next = '0;
        if (w_pick_valid) begin
          w_state_next = own_state(w_pick_id);
          w_last_next  = w_pick_id;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        // A stalled owner keeps everything frozen; lock only delays the hand-over.
        if (w_busy) begin
          w_state_next = r_state;
        end else if (w_oth_req && (!w_own_lock || r_hold_cnt == HOLD_LAST)) begin
          w_state_next = own_state(~w_owner_id);
          w_last_next  = ~w_owner_id;
          w_hold_next  = '0;
        end else if (w_oth_req) begin
          w_hold_next = r_hold_cnt + 1'b1;
        end else begin
          w_hold_next = '0;
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
        w_hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_last     <= w_last_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  always_comb begin
    w_fwd_req    = 1'b0;
    w_fwd_we     = 1'b0;
    w_fwd_addr   = '0;
    w_fwd_wdata  = '0;
    m0.mem_rdata = '0;
    m0.mem_ready = 1'b0;
    m1.mem_rdata = '0;
    m1.mem_ready = 1'b0;
    if (r_state == ARB_OWN0) begin
      w_fwd_req    = m0.mem_req;
      w_fwd_we     = m0.mem_we;
      w_fwd_addr   = m0.mem_addr;
      w_fwd_wdata  = m0.mem_wdata;
      m0.mem_rdata = s.mem_rdata;
      m0.mem_ready = s.mem_ready & m0.mem_req;
    end else if (r_state == ARB_OWN1) begin
      w_fwd_req    = m1.mem_req;
      w_fwd_we     = m1.mem_we;
      w_fwd_addr   = m1.mem_addr;
      w_fwd_wdata  = m1.mem_wdata;
      m1.mem_rdata = s.mem_rdata;
      m1.mem_ready = s.mem_ready & m1.mem_req;
    end
  end

  assign s.mem_req   = w_fwd_req;
  assign s.mem_we    = w_fwd_we;
  assign s.mem_addr  = w_fwd_addr;
  assign s.mem_wdata = w_fwd_wdata;
  assign s.mem_lock  = 1'b0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: vector table for basic/alternation traffic, hand sequences for lock, stall and reset.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic bram_ready;
  logic init_mem;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  bram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  bram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  bram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  // BRAM model: same-cycle ready, combinational read, write on the edge
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (s_if.mem_req && s_if.mem_we && s_if.mem_ready) begin
      mem[s_if.mem_addr[7:2]] <= s_if.mem_wdata;
    end
  end
  assign s_if.mem_rdata = mem[s_if.mem_addr[7:2]];
  assign s_if.mem_ready = bram_ready;

  typedef struct {
    logic        rst;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wd;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wd;
    logic        srdy;
    logic        e_m0rdy, e_m1rdy, e_sreq, e_swe;
    logic [31:0] e_saddr, e_swd, e_m0rd, e_m1rd;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_m0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic lock);
    m0_if.mem_req = req; m0_if.mem_we = we; m0_if.mem_addr = addr;
    m0_if.mem_wdata = wd; m0_if.mem_lock = lock;
  endtask

  task automatic drv_m1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic lock);
    m1_if.mem_req = req; m1_if.mem_we = we; m1_if.mem_addr = addr;
    m1_if.mem_wdata = wd; m1_if.mem_lock = lock;
  endtask

  task automatic expect_rdy(input string tag, input logic e0, input logic e1);
    @(negedge clk);
    chk({tag, ".m0_ready"}, 32'(m0_if.mem_ready), 32'(e0));
    chk({tag, ".m1_ready"}, 32'(m1_if.mem_ready), 32'(e1));
    $display("%s: m0_ready=%0b m1_ready=%0b s_req=%0b s_addr=%h", tag,
             m0_if.mem_ready, m1_if.mem_ready, s_if.mem_req, s_if.mem_addr);
  endtask

  initial begin
    //          rst m0:req we addr         wdata         m1:req we addr         wd   srdy  e:m0r m1r sreq swe saddr       swd           m0rd          m1rd
    tbl[0]  = '{1, 1,0,32'h10,32'h0,          0,0,32'h0, 32'h0, 1, 0,0,0,0,32'h0, 32'h0,          32'h0,          32'h0};
    tbl[1]  = '{0, 1,0,32'h10,32'h0,          0,0,32'h0, 32'h0, 1, 0,0,0,0,32'h0, 32'h0,          32'h0,          32'h0};
    tbl[2]  = '{0, 1,0,32'h10,32'h0,          0,0,32'h0, 32'h0, 1, 1,0,1,0,32'h10,32'h0,          32'h1000_0004,  32'h0};
    tbl[3]  = '{0, 1,0,32'h14,32'h0,          0,0,32'h0, 32'h0, 1, 1,0,1,0,32'h14,32'h0,          32'h1000_0005,  32'h0};
    tbl[4]  = '{0, 1,0,32'h18,32'h0,          0,0,32'h0, 32'h0, 1, 1,0,1,0,32'h18,32'h0,          32'h1000_0006,  32'h0};
    tbl[5]  = '{0, 0,0,32'h0, 32'h0,          0,0,32'h0, 32'h0, 1, 0,0,0,0,32'h0, 32'h0,          32'h1000_0000,  32'h0};
    tbl[6]  = '{1, 0,0,32'h0, 32'h0,          0,0,32'h0, 32'h0, 1, 0,0,0,0,32'h0, 32'h0,          32'h1000_0000,  32'h0};
    tbl[7]  = '{0, 1,1,32'h0, 32'hAAAA_0000,  1,0,32'h40,32'h0, 1, 0,0,0,0,32'h0, 32'h0,          32'h0,          32'h0};
    tbl[8]  = '{0, 1,1,32'h0, 32'hAAAA_0000,  1,0,32'h40,32'h0, 1, 1,0,1,1,32'h0, 32'hAAAA_0000,  32'h1000_0000,  32'h0};
    tbl[9]  = '{0, 1,1,32'h4, 32'hAAAA_0001,  1,0,32'h40,32'h0, 1, 0,1,1,0,32'h40,32'h0,          32'h0,          32'h1000_0010};
    tbl[10] = '{0, 1,1,32'h4, 32'hAAAA_0001,  1,0,32'h0, 32'h0, 1, 1,0,1,1,32'h4, 32'hAAAA_0001,  32'h1000_0001,  32'h0};
    tbl[11] = '{0, 1,1,32'h8, 32'hAAAA_0002,  1,0,32'h0, 32'h0, 1, 0,1,1,0,32'h0, 32'h0,          32'h0,          32'hAAAA_0000};
    tbl[12] = '{0, 1,1,32'h8, 32'hAAAA_0002,  1,0,32'h4, 32'h0, 1, 1,0,1,1,32'h8, 32'hAAAA_0002,  32'h1000_0002,  32'h0};
    tbl[13] = '{0, 0,0,32'h0, 32'h0,          1,0,32'h4, 32'h0, 1, 0,1,1,0,32'h4, 32'h0,          32'h0,          32'hAAAA_0001};
    tbl[14] = '{0, 0,0,32'h0, 32'h0,          1,0,32'h8, 32'h0, 1, 0,1,1,0,32'h8, 32'h0,          32'h0,          32'hAAAA_0002};

    rst = 1'b1;
    bram_ready = 1'b1;
    init_mem = 1'b1;
    drv_m0(0, 0, 0, 0, 0);
    drv_m1(0, 0, 0, 0, 0);
    repeat (2) next_cycle();
    init_mem = 1'b0;

    // single master, then contention with strict alternation and readback
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;
      bram_ready = tbl[i].srdy;
      drv_m0(tbl[i].m0_req, tbl[i].m0_we, tbl[i].m0_addr, tbl[i].m0_wd, 1'b0);
      drv_m1(tbl[i].m1_req, tbl[i].m1_we, tbl[i].m1_addr, tbl[i].m1_wd, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d.m0_ready", i), 32'(m0_if.mem_ready), 32'(tbl[i].e_m0rdy));
      chk($sformatf("v%0d.m1_ready", i), 32'(m1_if.mem_ready), 32'(tbl[i].e_m1rdy));
      chk($sformatf("v%0d.s_req", i),    32'(s_if.mem_req),    32'(tbl[i].e_sreq));
      chk($sformatf("v%0d.s_we", i),     32'(s_if.mem_we),     32'(tbl[i].e_swe));
      chk($sformatf("v%0d.s_addr", i),   s_if.mem_addr,        tbl[i].e_saddr);
      chk($sformatf("v%0d.s_wdata", i),  s_if.mem_wdata,       tbl[i].e_swd);
      chk($sformatf("v%0d.m0_rdata", i), m0_if.mem_rdata,      tbl[i].e_m0rd);
      chk($sformatf("v%0d.m1_rdata", i), m1_if.mem_rdata,      tbl[i].e_m1rd);
      $display("vec %0d: s_req=%0b s_we=%0b s_addr=%h m0_ready=%0b m1_ready=%0b",
               i, s_if.mem_req, s_if.mem_we, s_if.mem_addr, m0_if.mem_ready, m1_if.mem_ready);
      next_cycle();
    end

    // m1 RMW under lock for 3 cycles, m0 waiting; m0 granted right after lock drops
    drv_m0(1, 0, 32'h10, 0, 0);
    drv_m1(1, 1, 32'h20, 32'h55, 1);
    expect_rdy("lockA0", 0, 1); next_cycle();
    drv_m1(1, 0, 32'h20, 0, 1);
    expect_rdy("lockA1", 0, 1);
    chk("lockA1.m1_rdata", m1_if.mem_rdata, 32'h55); next_cycle();
    drv_m1(1, 1, 32'h20, 32'h56, 1);
    expect_rdy("lockA2", 0, 1); next_cycle();
    drv_m1(0, 0, 0, 0, 0);
    expect_rdy("lockA3", 0, 0); next_cycle();
    expect_rdy("lockA4", 1, 0);
    chk("lockA4.m0_rdata", m0_if.mem_rdata, 32'h1000_0004); next_cycle();

    // m1 holds lock indefinitely (with one idle gap); m0 gets in after LOCK_MAX cycles
    drv_m0(0, 0, 0, 0, 0);
    drv_m1(1, 0, 32'h40, 0, 1);
    expect_rdy("lockB_sw", 0, 0); next_cycle();
    for (int k = 0; k < 8; k++) begin
      drv_m0(1, 0, 32'h14, 0, 0);
      drv_m1((k == 3) ? 1'b0 : 1'b1, 0, 32'h40, 0, 1);
      expect_rdy($sformatf("lockB_wait%0d", k), 0, (k == 3) ? 1'b0 : 1'b1);
      next_cycle();
    end
    expect_rdy("lockB_grant", 1, 0);
    chk("lockB.hold_cnt", 32'(dut.r_hold_cnt), 32'h0);
    chk("lockB.m0_rdata", m0_if.mem_rdata, 32'h1000_0005); next_cycle();

    // slave stall during an m0 write while m1 waits
    drv_m0(1, 1, 32'h30, 32'h77, 0);
    drv_m1(1, 0, 32'h40, 0, 0);
    expect_rdy("stall_pre", 0, 1);
    chk("stall_pre.m1_rdata", m1_if.mem_rdata, 32'h1000_0010); next_cycle();
    drv_m1(1, 0, 32'h44, 0, 0);
    bram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_rdy($sformatf("stall%0d", k), 0, 0);
      chk($sformatf("stall%0d.s_req", k), 32'(s_if.mem_req), 32'h1);
      chk($sformatf("stall%0d.s_addr", k), s_if.mem_addr, 32'h30);
      chk($sformatf("stall%0d.s_wdata", k), s_if.mem_wdata, 32'h77);
      chk($sformatf("stall%0d.state", k), 32'(dut.r_state), 32'(ARB_OWN0));
      next_cycle();
    end
    bram_ready = 1'b1;
    expect_rdy("stall_done", 1, 0); next_cycle();
    drv_m0(0, 0, 0, 0, 0);
    expect_rdy("stall_m1", 0, 1);
    chk("stall_m1.m1_rdata", m1_if.mem_rdata, 32'h1000_0011); next_cycle();
    drv_m1(1, 0, 32'h30, 0, 0);
    expect_rdy("stall_rb", 0, 1);
    chk("stall_rb.m1_rdata", m1_if.mem_rdata, 32'h77); next_cycle();

    // reset while m1 owns; afterwards a tie goes to m0
    drv_m1(1, 0, 32'h40, 0, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drv_m0(1, 0, 32'h10, 0, 0);
    drv_m1(1, 0, 32'h14, 0, 0);
    expect_rdy("rst_idle", 0, 0);
    chk("rst_idle.s_req", 32'(s_if.mem_req), 32'h0);
    chk("rst_idle.m1_rdata", m1_if.mem_rdata, 32'h0);
    chk("rst_idle.state", 32'(dut.r_state), 32'(ARB_IDLE)); next_cycle();
    expect_rdy("rst_tie", 1, 0);
    chk("rst_tie.m0_rdata", m0_if.mem_rdata, 32'h1000_0004); next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Two-master arbiter that shares one port of the dual-port BRAM between two requesters, e.g. core LSU on m0 and DMA/debug on m1. A registered grant FSM parks on the last owner, so a lone master gets zero added latency. Round-robin selection applies under contention. An optional lock holds the grant for read-modify-write sequences, bounded by LOCK_MAX. The slave side connects directly to one BRAM port using the standard mem req/we/addr/wdata/rdata/ready bundle.

Parameters:
ADDR_W, `XLEN (32), address width of all ports
DATA_W, `XLEN (32), data width of all ports
LOCK_MAX, 8, max cycles an owner may hold the grant via lock while the other master waits; must be >= 1

Ports:
clk  input  1  clock; single clock domain
rst  input  1  synchronous, active-high reset
m0_mem_req  input  1  master 0 request; held until ready
m0_mem_we  input  1  master 0 write enable
m0_mem_addr  input  ADDR_W  master 0 byte address
m0_mem_wdata  input  DATA_W  master 0 write data
m0_mem_lock  input  1  master 0 requests to keep the grant
m0_mem_rdata  output  DATA_W  master 0 read data
m0_mem_ready  output  1  master 0 handshake complete
m1_mem_req, m1_mem_we, m1_mem_addr, m1_mem_wdata, m1_mem_lock, m1_mem_rdata, m1_mem_ready  same as m0, for master 1
s_mem_req  output  1  request to BRAM port
s_mem_we  output  1  write enable to BRAM port
s_mem_addr  output  ADDR_W  address to BRAM port
s_mem_wdata  output  DATA_W  write data to BRAM port
s_mem_rdata  input  DATA_W  read data from BRAM port
s_mem_ready  input  1  BRAM handshake

Behaviour:
- Interface: one clock, clk. Reset is rst: synchronous, active-high.
- Registers:
  - state: IDLE, OWN0 or OWN1.
  - last: id of the most recent grant.
  - hold_cnt: $clog2(LOCK_MAX+1) bits.
- Reset: state=IDLE, last=1 (m0 wins the first tie), hold_cnt=0.
- IDLE outputs: s_mem_req/we/addr/wdata=0; m*_ready=0; m*_rdata=0.
- OWNx outputs, combinational mux from the owner only:
  - s_mem_{req,we,addr,wdata} = mx_mem_*.
  - mx_mem_rdata = s_mem_rdata.
  - mx_mem_ready = s_mem_ready & mx_mem_req.
  - Non-owner: ready=0, rdata=0.
- The grant depends only on registered state. There is no combinational path from m*_req to any s_mem_* select.
- Definitions:
  - hs = mx_mem_req & s_mem_ready (owner handshake).
  - busy = mx_mem_req & !s_mem_ready.
  - oreq = the other master's req.
- IDLE transitions:
  - No req: stay IDLE.
  - Only mY req: go to OWNY, last<=Y.
  - Both req: go to OWN(!last), last<=!last.
  - Latency from IDLE: req seen in cycle N, forwarded and handshaken in N+1 (BRAM ready is same-cycle).
- OWNx transitions, evaluated every cycle:
  - busy: stay. Never switch mid-transaction.
  - oreq && (!mx_mem_lock || hold_cnt==LOCK_MAX-1): switch to OWN(other), last<=other, hold_cnt<=0. This applies with or without hs in this cycle.
  - Otherwise stay (park).
  - hold_cnt increments while in OWNx && oreq && mx_mem_lock && hold_cnt<LOCK_MAX-1. It clears on grant change, and clears when !oreq.
- Throughput:
  - Lone master: one transfer per cycle, indefinitely.
  - Both masters, no lock: strict alternation m0,m1,m0,...
- The owner's lock is honoured even when the owner has req=0, i.e. a gap inside an RMW. It is still bounded by LOCK_MAX.
- The non-owner's lock is ignored.
- Simultaneous same-address writes from both masters are impossible: only one is forwarded per cycle.
- Reset mid-transaction: rst=1 forces IDLE at the next edge. Outputs are 0 in the following cycle. Any request in flight must be reissued.
- Slave stall (s_mem_ready=0): the grant, hold_cnt and the forwarded signals are held. The master holds req/addr/wdata per the handshake rule.

Decomposition:
- State encodings (ARB_IDLE/ARB_OWN0/ARB_OWN1) go as `define constants in defines.vh.
- The bundle uses the existing MEM_REQ_PORTS/MEM_RSP_PORTS macros. A lock-bit macro is added if needed.
- One natural sub-module: arb_rr2_pick, combinational. Inputs are req0, req1 and last; output is winner id plus valid. It is used for the IDLE and switch decisions.

Test Plan:
- Reset, then m0 read of 0x10 in cycle 1 → s_mem_req=1 in cycle 2, m0_ready=1 in cycle 2, m1_ready=0. Back-to-back m0 reads of 0x14, 0x18 in cycles 3 and 4 each complete in the same cycle.
- After reset, both masters request every cycle, no lock → grants m0,m1,m0,m1. m0 writes 0xAAAA_0000+n to addr 4n; readback by m1 returns the expected values.
- m1 owns with lock=1 and does reads/writes for 3 cycles; m0 requests throughout with LOCK_MAX=8 → m0_ready stays 0 until m1 drops lock, then m0 is granted in the next cycle.
- m1 holds lock=1 forever while m0 requests → m0 is granted exactly LOCK_MAX cycles after m0 began waiting (cycle of first oreq + 8). hold_cnt then reads 0.
- s_mem_ready forced 0 for 3 cycles during an m0 write while m1 requests → grant stays OWN0 and s_mem_addr/wdata are stable. m1 is granted only after the m0 handshake.
- rst=1 asserted during an m1 request in OWN1 → next cycle all outputs are 0 and state is IDLE. After release, a simultaneous m0+m1 request grants m0 first.
